// File: rtl/multi_debounce_sync.sv
// Multi-channel input conditioner: per-channel synchroniser, tick-sampled counter debounce,
// registered level with rise/fall pulses and optional hold-to-repeat press pulses.

module mds_lane #(
    parameter int SYNC_STAGES    = 2,
    parameter int STABLE_SAMPLES = 4,
    parameter int REPEAT_DELAY   = 0,
    parameter int REPEAT_RATE    = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic tick_i,
    input  logic in_i,
    output logic level_o,
    output logic rise_o,
    output logic fall_o,
    output logic press_o
);
    localparam int SW = (STABLE_SAMPLES > 1) ? $clog2(STABLE_SAMPLES) : 1;
    localparam logic [SW-1:0] STAB_MAX = SW'(STABLE_SAMPLES - 1);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   synced;
    logic [SW-1:0]          stab_q, stab_d;
    logic                   level_q, level_d;
    logic                   rise_q, rise_d;
    logic                   fall_q, fall_d;
    logic                   press_q;
    logic                   rpt_fire;

    assign synced = sync_q[SYNC_STAGES-1];

    always_comb begin
        stab_d  = stab_q;
        level_d = level_q;
        rise_d  = 1'b0;
        fall_d  = 1'b0;
        if (tick_i) begin
            if (synced == level_q) begin
                stab_d = '0;
            end else if (stab_q == STAB_MAX) begin
                level_d = synced;
                stab_d  = '0;
                rise_d  = synced;
                fall_d  = ~synced;
            end else begin
                stab_d = stab_q + SW'(1);
            end
        end
    end

    generate
        if (REPEAT_DELAY > 0) begin : g_rpt
            localparam int RMAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
            localparam int RW   = $clog2(RMAX + 1);
            logic [RW-1:0] rpt_q, rpt_d, rpt_inc;
            logic          armed_q, armed_d;

            // A release landing on a repeat tick wins: the repeat is dropped.
            always_comb begin
                rpt_inc  = rpt_q + RW'(1);
                rpt_d    = rpt_q;
                armed_d  = armed_q;
                rpt_fire = 1'b0;
                if (!level_q || rise_d) begin
                    rpt_d   = '0;
                    armed_d = 1'b0;
                end else if (tick_i) begin
                    if (!armed_q && rpt_inc == RW'(REPEAT_DELAY)) begin
                        rpt_fire = ~fall_d;
                        armed_d  = 1'b1;
                        rpt_d    = '0;
                    end else if (armed_q && rpt_inc == RW'(REPEAT_RATE)) begin
                        rpt_fire = ~fall_d;
                        rpt_d    = '0;
                    end else begin
                        rpt_d = rpt_inc;
                    end
                end
            end

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    rpt_q   <= '0;
                    armed_q <= 1'b0;
                end else begin
                    rpt_q   <= rpt_d;
                    armed_q <= armed_d;
                end
            end
        end else begin : g_norpt
            assign rpt_fire = 1'b0;
        end
    endgenerate

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q  <= '0;
            stab_q  <= '0;
            level_q <= 1'b0;
            rise_q  <= 1'b0;
            fall_q  <= 1'b0;
            press_q <= 1'b0;
        end else begin
            sync_q  <= {sync_q[SYNC_STAGES-2:0], in_i};
            stab_q  <= stab_d;
            level_q <= level_d;
            rise_q  <= rise_d;
            fall_q  <= fall_d;
            press_q <= rise_d | rpt_fire;
        end
    end

    assign level_o = level_q;
    assign rise_o  = rise_q;
    assign fall_o  = fall_q;
    assign press_o = press_q;
endmodule

module multi_debounce_sync #(
    parameter int N_CH           = 5,
    parameter int SYNC_STAGES    = 2,
    parameter int TICK_DIV       = 100000,
    parameter int STABLE_SAMPLES = 4,
    parameter int REPEAT_DELAY   = 0,
    parameter int REPEAT_RATE    = 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [N_CH-1:0] in_i,
    output logic [N_CH-1:0] level_o,
    output logic [N_CH-1:0] rise_o,
    output logic [N_CH-1:0] fall_o,
    output logic [N_CH-1:0] press_o,
    output logic            tick_o
);
    localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CW-1:0] DIV_MAX = CW'(TICK_DIV - 1);

    logic [CW-1:0] cnt_q, cnt_d;
    logic          tick_q, tick_d;

    // tick is registered so it tracks cnt_q == DIV_MAX yet still reads 0 in reset.
    always_comb begin
        cnt_d  = (cnt_q == DIV_MAX) ? '0 : cnt_q + CW'(1);
        tick_d = (cnt_d == DIV_MAX);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q  <= '0;
            tick_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            tick_q <= tick_d;
        end
    end

    assign tick_o = tick_q;

    generate
        for (genvar i = 0; i < N_CH; i++) begin : g_lane
            mds_lane #(
                .SYNC_STAGES   (SYNC_STAGES),
                .STABLE_SAMPLES(STABLE_SAMPLES),
                .REPEAT_DELAY  (REPEAT_DELAY),
                .REPEAT_RATE   (REPEAT_RATE)
            ) u_lane (
                .clk    (clk),
                .rst    (rst),
                .tick_i (tick_q),
                .in_i   (in_i[i]),
                .level_o(level_o[i]),
                .rise_o (rise_o[i]),
                .fall_o (fall_o[i]),
                .press_o(press_o[i])
            );
        end
    endgenerate
endmodule

// File: tb/tb_multi_debounce_sync.sv
// Directed bench for multi_debounce_sync: three instances cover the base config,
// a divided prescaler and auto-repeat.

module tb_multi_debounce_sync;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [1:0] in_a = '0, in_b = '0, in_c = '0;
    logic [1:0] lvl_a, rise_a, fall_a, press_a;
    logic [1:0] lvl_b, rise_b, fall_b, press_b;
    logic [1:0] lvl_c, rise_c, fall_c, press_c;
    logic       tick_a, tick_b, tick_c;
    int         n_tests = 0;
    int         n_fail  = 0;

    always #5 clk = ~clk;

    multi_debounce_sync #(.N_CH(2), .SYNC_STAGES(2), .TICK_DIV(1), .STABLE_SAMPLES(4),
                          .REPEAT_DELAY(0), .REPEAT_RATE(1)) u_a (
        .clk(clk), .rst(rst), .in_i(in_a), .level_o(lvl_a), .rise_o(rise_a),
        .fall_o(fall_a), .press_o(press_a), .tick_o(tick_a));

    multi_debounce_sync #(.N_CH(2), .SYNC_STAGES(2), .TICK_DIV(4), .STABLE_SAMPLES(4),
                          .REPEAT_DELAY(0), .REPEAT_RATE(1)) u_b (
        .clk(clk), .rst(rst), .in_i(in_b), .level_o(lvl_b), .rise_o(rise_b),
        .fall_o(fall_b), .press_o(press_b), .tick_o(tick_b));

    multi_debounce_sync #(.N_CH(2), .SYNC_STAGES(2), .TICK_DIV(1), .STABLE_SAMPLES(4),
                          .REPEAT_DELAY(10), .REPEAT_RATE(3)) u_c (
        .clk(clk), .rst(rst), .in_i(in_c), .level_o(lvl_c), .rise_o(rise_c),
        .fall_o(fall_c), .press_o(press_c), .tick_o(tick_c));

    task automatic do_reset();
        rst  = 1'b1;
        in_a = '0; in_b = '0; in_c = '0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_reset();
        logic [8:0] obs;
        rst  = 1'b1;
        in_a = '0; in_b = '0; in_c = '0;
        repeat (2) @(negedge clk);
        obs = {lvl_a, rise_a, fall_a, press_a, tick_a};
        n_tests++;
        if (obs !== 9'd0) begin n_fail++; $display("FAIL reset_a got=%b exp=0", obs); end
        obs = {lvl_b, rise_b, fall_b, press_b, tick_b};
        n_tests++;
        if (obs !== 9'd0) begin n_fail++; $display("FAIL reset_b got=%b exp=0", obs); end
        obs = {lvl_c, rise_c, fall_c, press_c, tick_c};
        n_tests++;
        if (obs !== 9'd0) begin n_fail++; $display("FAIL reset_c got=%b exp=0", obs); end
        rst = 1'b0;
        @(negedge clk);
        n_tests++;
        if ({tick_a, tick_b} !== 2'b10) begin
            n_fail++; $display("FAIL tick_after_release got=%b exp=10", {tick_a, tick_b});
        end
    endtask

    task automatic test_clean_press();
        logic [7:0] obs, exp;
        do_reset();
        in_a = 2'b01;
        for (int e = 0; e <= 8; e++) begin
            @(negedge clk);
            obs = {lvl_a, rise_a, fall_a, press_a};
            exp = {1'b0, e >= 5, 1'b0, e == 5, 2'b00, 1'b0, e == 5};
            n_tests++;
            if (obs !== exp) begin
                n_fail++; $display("FAIL clean_press e=%0d got=%b exp=%b", e, obs, exp);
            end
        end
    endtask

    task automatic test_glitch();
        logic [7:0] obs, exp;
        do_reset();
        in_a = 2'b01;
        for (int e = 0; e <= 11; e++) begin
            @(negedge clk);
            obs = {lvl_a, rise_a, fall_a, press_a};
            n_tests++;
            if (obs !== 8'd0) begin
                n_fail++; $display("FAIL glitch_reject e=%0d got=%b exp=0", e, obs);
            end
            if (e == 2) in_a = 2'b00;
        end
        in_a = 2'b01;
        for (int e = 0; e <= 8; e++) begin
            @(negedge clk);
            obs = {lvl_a, rise_a, fall_a, press_a};
            exp = {1'b0, e >= 5, 1'b0, e == 5, 2'b00, 1'b0, e == 5};
            n_tests++;
            if (obs !== exp) begin
                n_fail++; $display("FAIL glitch_then_hold e=%0d got=%b exp=%b", e, obs, exp);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] obs, exp;
        logic [1:0] lv, r, f;
        do_reset();
        in_a = 2'b01;
        for (int e = 0; e <= 17; e++) begin
            @(negedge clk);
            lv  = {e >= 7 && e < 15, e >= 5 && e < 15};
            r   = {e == 7, e == 5};
            f   = (e == 15) ? 2'b11 : 2'b00;
            exp = {lv, r, f, r};
            obs = {lvl_a, rise_a, fall_a, press_a};
            n_tests++;
            if (obs !== exp) begin
                n_fail++; $display("FAIL back_to_back e=%0d got=%b exp=%b", e, obs, exp);
            end
            if (e == 1) in_a = 2'b11;
            if (e == 9) in_a = 2'b00;
        end
    endtask

    task automatic test_prescaler();
        logic [6:0] obs, exp;
        rst  = 1'b1;
        in_a = '0; in_b = '0; in_c = '0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        for (int j = 1; j <= 40; j++) begin
            @(negedge clk);
            obs = {tick_b, lvl_b, rise_b, fall_b};
            exp = {(j % 4) == 3, 1'b0, j >= 28, 1'b0, j == 28, 2'b00};
            n_tests++;
            if (obs !== exp) begin
                n_fail++; $display("FAIL prescaler j=%0d got=%b exp=%b", j, obs, exp);
            end
            if (j == 12) in_b = 2'b01;
            if (j == 28) in_b = 2'b00;
            if (j == 29) in_b = 2'b01;
        end
    endtask

    task automatic test_auto_repeat();
        logic [7:0] obs, exp;
        logic       lv, r, f, p;
        do_reset();
        in_c = 2'b01;
        for (int e = 0; e <= 50; e++) begin
            @(negedge clk);
            lv  = (e >= 5) && (e < 42);
            r   = (e == 5);
            f   = (e == 42);
            p   = (e == 5) || (e >= 15 && e <= 39 && ((e - 15) % 3) == 0);
            exp = {1'b0, lv, 1'b0, r, 1'b0, f, 1'b0, p};
            obs = {lvl_c, rise_c, fall_c, press_c};
            n_tests++;
            if (obs !== exp) begin
                n_fail++; $display("FAIL auto_repeat e=%0d got=%b exp=%b", e, obs, exp);
            end
            if (e == 36) in_c = 2'b00;
        end
    endtask

    task automatic test_reset_mid_op();
        logic [8:0] obs9;
        logic [7:0] obs, exp;
        do_reset();
        in_a = 2'b10;
        for (int e = 0; e <= 12; e++) begin
            @(negedge clk);
            if (e == 8) in_a = 2'b11;
        end
        n_tests++;
        if (lvl_a !== 2'b10) begin
            n_fail++; $display("FAIL pre_reset_level got=%b exp=10", lvl_a);
        end
        rst = 1'b1;
        #1;
        obs9 = {lvl_a, rise_a, fall_a, press_a, tick_a};
        n_tests++;
        if (obs9 !== 9'd0) begin
            n_fail++; $display("FAIL async_reset got=%b exp=0", obs9);
        end
        @(negedge clk);
        rst = 1'b0;
        for (int e = 0; e <= 7; e++) begin
            @(negedge clk);
            exp = {(e >= 5) ? 2'b11 : 2'b00, (e == 5) ? 2'b11 : 2'b00, 2'b00,
                   (e == 5) ? 2'b11 : 2'b00};
            obs = {lvl_a, rise_a, fall_a, press_a};
            n_tests++;
            if (obs !== exp) begin
                n_fail++; $display("FAIL reset_restart e=%0d got=%b exp=%b", e, obs, exp);
            end
        end
    endtask

    initial begin
        test_reset();
        test_clean_press();
        test_glitch();
        test_back_to_back();
        test_prescaler();
        test_auto_repeat();
        test_reset_mid_op();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
